// File: rtl/norm_divider_seq_pkg.sv
// norm_pkg: shared types and constant helpers for the iterative row normaliser.
//   - norm_state_e : controller states
//   - acc_width    : sum-of-squares accumulator width, 2W + clog2(M)
//   - norm_width   : width of floor(sqrt(acc)), ceil(AW/2)
//   - sat_maxpos / sat_maxneg : symmetric saturation limits for a W-bit result
package norm_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACC  = 3'd1,
        SQRT = 3'd2,
        DIV  = 3'd3,
        DONE = 3'd4
    } norm_state_e;

    function automatic int acc_width(input int w, input int m);
        return 2 * w + $clog2(m);
    endfunction

    function automatic int norm_width(input int w, input int m);
        return (acc_width(w, m) + 1) / 2;
    endfunction

    function automatic longint sat_maxpos(input int w);
        return (longint'(1) << (w - 1)) - longint'(1);
    endfunction

    // Symmetric clamp: the most negative code is never produced.
    function automatic longint sat_maxneg(input int w);
        return -sat_maxpos(w);
    endfunction

endpackage

// File: rtl/norm_divider_seq_divider.sv
// serial_divider_u: unsigned restoring divider, one quotient bit per cycle.
//   clk, rst   : clock, synchronous active-high reset
//   load       : starts a division; the first quotient bit is produced in this cycle
//   dividend   : DDW-bit unsigned dividend, sampled on load
//   divisor    : DVW-bit unsigned divisor, sampled on load
//   quotient   : result, valid while done is high and held until the next load
//   done       : one-cycle pulse in the cycle after the last quotient bit
// A division occupies exactly DDW cycles counting the load cycle, so the caller
// can issue back-to-back loads every DDW cycles.
module serial_divider_u #(
    parameter int DDW = 39,
    parameter int DVW = 27
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [DDW-1:0] dividend,
    input  logic [DVW-1:0] divisor,
    output logic [DDW-1:0] quotient,
    output logic           done
);

    localparam int CW = $clog2(DDW + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DDW - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [DDW-1:0] dvd_r;
    logic [DDW-1:0] quo_r;
    logic [DVW-1:0] dvs_r;
    logic [DVW-1:0] rem_r;
    logic [CW-1:0]  cnt_r;
    logic           busy_r;
    logic           done_r;

    logic [DDW-1:0] src_dvd_s;
    logic [DDW-1:0] src_quo_s;
    logic [DVW-1:0] src_dvs_s;
    logic [DVW-1:0] src_rem_s;
    logic [DVW:0]   rem_sh_s;
    logic [DVW-1:0] rem_nx_s;
    logic           q_bit_s;
    logic [DDW-1:0] dvd_nx_s;
    logic [DDW-1:0] quo_nx_s;

    // One restoring step; on load the step starts from fresh operands.
    always_comb begin
        if (load) begin
            src_dvd_s = dividend;
            src_quo_s = {DDW{1'b0}};
            src_dvs_s = divisor;
            src_rem_s = {DVW{1'b0}};
        end else begin
            src_dvd_s = dvd_r;
            src_quo_s = quo_r;
            src_dvs_s = dvs_r;
            src_rem_s = rem_r;
        end
        rem_sh_s = {src_rem_s, src_dvd_s[DDW-1]};
        if (rem_sh_s >= {1'b0, src_dvs_s}) begin
            rem_nx_s = DVW'(rem_sh_s - {1'b0, src_dvs_s});
            q_bit_s  = 1'b1;
        end else begin
            rem_nx_s = DVW'(rem_sh_s);
            q_bit_s  = 1'b0;
        end
        dvd_nx_s = DDW'({src_dvd_s, 1'b0});
        quo_nx_s = DDW'({src_quo_s, q_bit_s});
    end

    // Iteration registers and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_r  <= {DDW{1'b0}};
            quo_r  <= {DDW{1'b0}};
            dvs_r  <= {DVW{1'b0}};
            rem_r  <= {DVW{1'b0}};
            cnt_r  <= {CW{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (load) begin
            dvd_r  <= dvd_nx_s;
            quo_r  <= quo_nx_s;
            dvs_r  <= divisor;
            rem_r  <= rem_nx_s;
            cnt_r  <= CNT_LOAD;
            busy_r <= (DDW > 1);
            done_r <= (DDW == 1);
        end else if (busy_r) begin
            dvd_r <= dvd_nx_s;
            quo_r <= quo_nx_s;
            rem_r <= rem_nx_s;
            cnt_r <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end else begin
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign quotient = quo_r;
    assign done     = done_r;

endmodule

// File: rtl/norm_divider_seq.sv
// norm_divider_seq: divides every row of an N x M signed Q.FRAC matrix by its
// Euclidean norm, sharing one MAC, one bit-serial sqrt and one serial divider.
//   clk_norm, rst_norm : clock, synchronous active-high reset (aborts a run)
//   start              : request, accepted only in IDLE
//   w_in               : flattened input matrix, element (r,c) at [(r*M+c)*W +: W]
//   busy               : run in progress
//   done               : one-cycle pulse, w_out/err flags updated in this cycle
//   w_out              : normalised matrix, held until the next done
//   err_zero, err_sat  : a row had zero norm / a quotient was clamped
// Per row: M accumulate cycles, NW sqrt cycles, M*(W+FRAC) divide cycles.
module norm_divider_seq
    import norm_pkg::*;
#(
    parameter int W    = 26,
    parameter int FRAC = 13,
    parameter int N    = 4,
    parameter int M    = 4
) (
    input  logic             clk_norm,
    input  logic             rst_norm,
    input  logic             start,
    input  logic [N*M*W-1:0] w_in,
    output logic             busy,
    output logic             done,
    output logic [N*M*W-1:0] w_out,
    output logic             err_zero,
    output logic             err_sat
);

    localparam int NW  = norm_width(W, M);
    localparam int RW  = 2 * NW;              // radicand width, AW rounded up to even
    localparam int SRW = NW + 2;              // sqrt partial remainder width
    localparam int DW  = W + FRAC;            // dividend width
    localparam int NE  = N * M;
    localparam int RIW = (N > 1) ? $clog2(N) : 1;
    localparam int CIW = (M > 1) ? $clog2(M) : 1;
    localparam int EIW = (NE > 1) ? $clog2(NE) : 1;
    localparam int KW  = $clog2(((DW > NW) ? DW : NW) + 1);

    localparam logic [RIW-1:0] ROW_LAST = RIW'(N - 1);
    localparam logic [CIW-1:0] COL_LAST = CIW'(M - 1);
    localparam logic [KW-1:0]  SQ_LAST  = KW'(NW - 1);
    localparam logic [KW-1:0]  DV_LAST  = KW'(DW - 1);
    localparam logic [W-1:0]   MAXPOS   = W'(sat_maxpos(W));
    localparam logic [W-1:0]   MAXNEG   = W'(sat_maxneg(W));
    localparam logic [DW-1:0]  QLIMIT   = DW'(sat_maxpos(W));

    norm_state_e state_r, next_state_s;

    logic signed [W-1:0] mat_r [NE];
    logic [W-1:0]        res_r [NE];
    logic [W-1:0]        res_next_s [NE];
    logic [RIW-1:0]      row_r;
    logic [CIW-1:0]      col_r;
    logic [KW-1:0]       cnt_r;
    logic [RW-1:0]       acc_r;
    logic [SRW-1:0]      sq_rem_r;
    logic [NW-1:0]       sq_root_r;
    logic                zero_acc_r;
    logic                sat_acc_r;
    logic [EIW-1:0]      pend_idx_r;
    logic                pend_neg_r;
    logic                pend_zero_r;
    logic                busy_r;
    logic                done_r;
    logic [N*M*W-1:0]    w_out_r;
    logic                err_zero_r;
    logic                err_sat_r;

    logic [EIW-1:0]      elem_idx_s;
    logic signed [W-1:0] elem_s;
    logic signed [2*W-1:0] sq_s;
    logic [2*W-1:0]      sq_u_s;
    logic [W-1:0]        abs_s;
    logic [DW-1:0]       dividend_s;
    logic [SRW+1:0]      rem_sh_s;
    logic [SRW+1:0]      trial_s;
    logic [SRW-1:0]      sq_rem_next_s;
    logic [NW-1:0]       sq_root_next_s;
    logic                div_load_s;
    logic [DW-1:0]       div_q_s;
    logic                div_done_s;
    logic [W-1:0]        q_val_s;
    logic                q_sat_s;
    logic                sat_next_s;

    assign elem_idx_s = EIW'(row_r) * EIW'(M) + EIW'(col_r);
    assign elem_s     = mat_r[elem_idx_s];
    assign sq_s       = (2*W)'(elem_s) * (2*W)'(elem_s);
    assign sq_u_s     = sq_s;
    assign dividend_s = {abs_s, {FRAC{1'b0}}};

    // Magnitude of the current element; -2^(W-1) maps cleanly to 2^(W-1).
    always_comb begin
        if (elem_s[W-1]) begin
            abs_s = -elem_s;
        end else begin
            abs_s = elem_s;
        end
    end

    // One bit of the restoring square root, consuming two radicand bits from the top of acc_r.
    always_comb begin
        rem_sh_s = {sq_rem_r, acc_r[RW-1 -: 2]};
        trial_s  = (SRW+2)'({sq_root_r, 2'b01});
        if (rem_sh_s >= trial_s) begin
            sq_rem_next_s  = SRW'(rem_sh_s - trial_s);
            sq_root_next_s = NW'({sq_root_r, 1'b1});
        end else begin
            sq_rem_next_s  = SRW'(rem_sh_s);
            sq_root_next_s = NW'({sq_root_r, 1'b0});
        end
    end

    serial_divider_u #(
        .DDW(DW),
        .DVW(NW)
    ) u_div (
        .clk      (clk_norm),
        .rst      (rst_norm),
        .load     (div_load_s),
        .dividend (dividend_s),
        .divisor  (sq_root_r),
        .quotient (div_q_s),
        .done     (div_done_s)
    );

    // Sign, clamp and zero-norm override for the quotient the divider just finished.
    always_comb begin
        q_val_s = {W{1'b0}};
        q_sat_s = 1'b0;
        if (pend_zero_r) begin
            q_val_s = {W{1'b0}};
        end else if (div_q_s > QLIMIT) begin
            q_sat_s = 1'b1;
            if (pend_neg_r) begin
                q_val_s = MAXNEG;
            end else begin
                q_val_s = MAXPOS;
            end
        end else if (pend_neg_r) begin
            q_val_s = -div_q_s[W-1:0];
        end else begin
            q_val_s = div_q_s[W-1:0];
        end
    end

    // Merge a finished quotient into the result set; also feeds w_out in DONE,
    // where the row's last quotient lands in the same cycle.
    always_comb begin
        res_next_s = res_r;
        sat_next_s = sat_acc_r;
        if (div_done_s) begin
            res_next_s[pend_idx_r] = q_val_s;
            sat_next_s             = sat_acc_r | q_sat_s;
        end else begin
            sat_next_s = sat_acc_r;
        end
    end

    // Controller next state and divider launch strobe.
    always_comb begin
        next_state_s = state_r;
        div_load_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = ACC;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ACC: begin
                if (col_r == COL_LAST) begin
                    next_state_s = SQRT;
                end else begin
                    next_state_s = ACC;
                end
            end
            SQRT: begin
                if (cnt_r == SQ_LAST) begin
                    next_state_s = DIV;
                end else begin
                    next_state_s = SQRT;
                end
            end
            DIV: begin
                div_load_s = (cnt_r == {KW{1'b0}});
                if ((cnt_r == DV_LAST) && (col_r == COL_LAST)) begin
                    if (row_r == ROW_LAST) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = ACC;
                    end
                end else begin
                    next_state_s = DIV;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk_norm) begin
        if (rst_norm) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Datapath: matrix capture, MAC, sqrt, divide sequencing, result publication.
    always_ff @(posedge clk_norm) begin
        if (rst_norm) begin
            for (int i = 0; i < NE; i++) begin
                mat_r[i] <= {W{1'b0}};
                res_r[i] <= {W{1'b0}};
            end
            row_r       <= {RIW{1'b0}};
            col_r       <= {CIW{1'b0}};
            cnt_r       <= {KW{1'b0}};
            acc_r       <= {RW{1'b0}};
            sq_rem_r    <= {SRW{1'b0}};
            sq_root_r   <= {NW{1'b0}};
            zero_acc_r  <= 1'b0;
            sat_acc_r   <= 1'b0;
            pend_idx_r  <= {EIW{1'b0}};
            pend_neg_r  <= 1'b0;
            pend_zero_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            w_out_r     <= {(N*M*W){1'b0}};
            err_zero_r  <= 1'b0;
            err_sat_r   <= 1'b0;
        end else begin
            res_r     <= res_next_s;
            sat_acc_r <= sat_next_s;
            done_r    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NE; i++) begin
                            mat_r[i] <= w_in[i*W +: W];
                        end
                        row_r      <= {RIW{1'b0}};
                        col_r      <= {CIW{1'b0}};
                        acc_r      <= {RW{1'b0}};
                        zero_acc_r <= 1'b0;
                        sat_acc_r  <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                ACC: begin
                    acc_r <= acc_r + RW'(sq_u_s);
                    if (col_r == COL_LAST) begin
                        col_r     <= {CIW{1'b0}};
                        cnt_r     <= {KW{1'b0}};
                        sq_rem_r  <= {SRW{1'b0}};
                        sq_root_r <= {NW{1'b0}};
                    end else begin
                        col_r <= col_r + CIW'(1);
                    end
                end
                SQRT: begin
                    acc_r     <= acc_r << 2;
                    sq_rem_r  <= sq_rem_next_s;
                    sq_root_r <= sq_root_next_s;
                    if (cnt_r == SQ_LAST) begin
                        cnt_r <= {KW{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + KW'(1);
                    end
                end
                DIV: begin
                    if (div_load_s) begin
                        pend_idx_r  <= elem_idx_s;
                        pend_neg_r  <= elem_s[W-1];
                        pend_zero_r <= (sq_root_r == {NW{1'b0}});
                        if (sq_root_r == {NW{1'b0}}) begin
                            zero_acc_r <= 1'b1;
                        end
                    end
                    if (cnt_r == DV_LAST) begin
                        cnt_r <= {KW{1'b0}};
                        if (col_r == COL_LAST) begin
                            col_r <= {CIW{1'b0}};
                            acc_r <= {RW{1'b0}};
                            if (row_r != ROW_LAST) begin
                                row_r <= row_r + RIW'(1);
                            end
                        end else begin
                            col_r <= col_r + CIW'(1);
                        end
                    end else begin
                        cnt_r <= cnt_r + KW'(1);
                    end
                end
                DONE: begin
                    for (int i = 0; i < NE; i++) begin
                        w_out_r[i*W +: W] <= res_next_s[i];
                    end
                    err_zero_r <= zero_acc_r;
                    err_sat_r  <= sat_next_s;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b1;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign w_out    = w_out_r;
    assign err_zero = err_zero_r;
    assign err_sat  = err_sat_r;

endmodule
